// File: rtl/sequence_generator_10010.sv
// Serial pattern transmitter for the 10010 sequence detector link.
// A start request emits a burst of PATTERN frames, MSB first, one bit per clock.
// Frames are separated by a programmable idle gap, or overlapped on the shared
// prefix/suffix when overlap mode is selected. All outputs are registered.
module sequence_generator_10010 #(
   parameter int unsigned        PAT_LEN = 5,
   parameter logic [PAT_LEN-1:0] PATTERN = 5'b10010,
   parameter int unsigned        OVL_LEN = 2,
   parameter int unsigned        COUNT_W = 4,
   parameter int unsigned        GAP_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COUNT_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0]   gap,
   input  logic               overlap,
   input  logic               abort,
   output logic               out,
   output logic               out_valid,
   output logic               frame_start,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] frame_cnt
);

   // Bit index width: enough to address every pattern bit.
   localparam int unsigned IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

   // Index of the first bit of a full frame and of an overlapped frame.
   localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(PAT_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_OVL  = IDX_W'(PAT_LEN - 1 - OVL_LEN);

   localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
   localparam logic [GAP_W-1:0]   GAP_ONE = GAP_W'(1);

   // FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // State and burst bookkeeping
   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;       // index of the bit currently on out
   logic [COUNT_W-1:0] rem_q, rem_d;       // frames left, including the current one
   logic [GAP_W-1:0]   gap_len_q, gap_len_d;
   logic               ovl_q, ovl_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [COUNT_W-1:0] frame_cnt_q, frame_cnt_d;

   // Registered outputs
   logic out_q, out_d;
   logic valid_q, valid_d;
   logic fs_q, fs_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   // Next-state and next-output logic; outputs describe the cycle after the edge.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      rem_d       = rem_q;
      gap_len_d   = gap_len_q;
      ovl_d       = ovl_q;
      gap_cnt_d   = gap_cnt_q;
      frame_cnt_d = frame_cnt_q;
      out_d       = 1'b0;
      valid_d     = 1'b0;
      fs_d        = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // start wins over abort here: abort has no meaning while idle
            if (start) begin
               rem_d       = (repeat_cnt == '0) ? CNT_ONE : repeat_cnt;
               gap_len_d   = gap;
               ovl_d       = overlap;
               frame_cnt_d = '0;
               idx_d       = IDX_FULL;
               state_d     = ST_SHIFT;
               out_d       = PATTERN[IDX_FULL];
               valid_d     = 1'b1;
               fs_d        = 1'b1;
               busy_d      = 1'b1;
            end
         end

         ST_SHIFT: begin
            if (abort) begin
               // Cancel quietly: no done pulse, frame count frozen.
               state_d = ST_IDLE;
            end else if (idx_q != '0) begin
               idx_d   = idx_q - 1'b1;
               out_d   = PATTERN[idx_d];
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end else begin
               // Last bit of a frame is on the line this cycle.
               frame_cnt_d = frame_cnt_q + 1'b1;
               if (rem_q <= CNT_ONE) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  rem_d  = rem_q - 1'b1;
                  busy_d = 1'b1;
                  if (ovl_q) begin
                     // Overlapped frame skips the bits shared with the previous one.
                     idx_d   = IDX_OVL;
                     out_d   = PATTERN[IDX_OVL];
                     valid_d = 1'b1;
                     fs_d    = 1'b1;
                  end else if (gap_len_q == '0) begin
                     idx_d   = IDX_FULL;
                     out_d   = PATTERN[IDX_FULL];
                     valid_d = 1'b1;
                     fs_d    = 1'b1;
                  end else begin
                     state_d   = ST_GAP;
                     gap_cnt_d = gap_len_q;
                  end
               end
            end
         end

         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               busy_d = 1'b1;
               if (gap_cnt_q <= GAP_ONE) begin
                  // Final idle cycle: next cycle carries the first bit of a full frame.
                  state_d = ST_SHIFT;
                  idx_d   = IDX_FULL;
                  out_d   = PATTERN[IDX_FULL];
                  valid_d = 1'b1;
                  fs_d    = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q - 1'b1;
               end
            end
         end

         ST_DONE: begin
            // start during the done cycle is deliberately dropped
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         rem_q       <= '0;
         gap_len_q   <= '0;
         ovl_q       <= 1'b0;
         gap_cnt_q   <= '0;
         frame_cnt_q <= '0;
         out_q       <= 1'b0;
         valid_q     <= 1'b0;
         fs_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rem_q       <= rem_d;
         gap_len_q   <= gap_len_d;
         ovl_q       <= ovl_d;
         gap_cnt_q   <= gap_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         out_q       <= out_d;
         valid_q     <= valid_d;
         fs_q        <= fs_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Drive ports straight from the output registers.
   always_comb begin
      out         = out_q;
      out_valid   = valid_q;
      frame_start = fs_q;
      busy        = busy_q;
      done        = done_q;
      frame_cnt   = frame_cnt_q;
   end

endmodule

// File: tb/tb_sequence_generator_10010.sv
// Directed bench for sequence_generator_10010. Cycle k is the k-th cycle after
// the edge that samples start; outputs are sampled on the falling edge.
module tb_sequence_generator_10010;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] repeat_cnt;
   logic [3:0] gap;
   logic       overlap;
   logic       abort;
   logic       out;
   logic       out_valid;
   logic       frame_start;
   logic       busy;
   logic       done;
   logic [3:0] frame_cnt;

   int checks = 0;
   int errors = 0;

   // Captured per-cycle traces, bit k = cycle k
   logic [63:0] cv, co, cfs, cb, cd;
   logic [3:0]  cfc [0:63];
   logic [63:0] ex;

   sequence_generator_10010 dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .repeat_cnt  (repeat_cnt),
      .gap         (gap),
      .overlap     (overlap),
      .abort       (abort),
      .out         (out),
      .out_valid   (out_valid),
      .frame_start (frame_start),
      .busy        (busy),
      .done        (done),
      .frame_cnt   (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Character i of s describes cycle i+1.
   function automatic logic [63:0] str2vec(input string s);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < s.len(); i++) begin
         if (s[i] == "1") r[i+1] = 1'b1;
      end
      return r;
   endfunction

   // Present a start request; configuration is scrambled right after sampling.
   task automatic do_start(input logic [3:0] rc, input logic [3:0] g, input logic ov);
      @(negedge clk);
      repeat_cnt = rc;
      gap        = g;
      overlap    = ov;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      abort      = 1'b0;
      repeat_cnt = 4'd7;
      gap        = 4'd0;
      overlap    = ~ov;
   endtask

   // Record n cycles; optionally pulse start at s1/s2 and abort at ab (0 = never).
   task automatic capture(input int n, input int s1, input int s2, input int ab);
      cv = '0; co = '0; cfs = '0; cb = '0; cd = '0;
      for (int k = 0; k < 64; k++) cfc[k] = '0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         cv[k]  = out_valid;
         co[k]  = out;
         cfs[k] = frame_start;
         cb[k]  = busy;
         cd[k]  = done;
         cfc[k] = frame_cnt;
         start  = (k == s1) || (k == s2);
         abort  = (k == ab);
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out, out_valid, frame_start, busy, done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b exp 00000", {out, out_valid, frame_start, busy, done});
      end
      checks++;
      if (frame_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, busy, done} !== 3'b0) begin
         errors++;
         $display("FAIL idle_after_reset got %b exp 000", {out_valid, busy, done});
      end
   endtask

   task automatic test_single();
      do_start(4'd1, 4'd3, 1'b0);
      capture(8, 0, 0, 0);
      ex = str2vec("11111000");
      checks++;
      if (cv !== ex) begin errors++; $display("FAIL single_valid got %b exp %b", cv, ex); end
      ex = str2vec("10010000");
      checks++;
      if (co !== ex) begin errors++; $display("FAIL single_out got %b exp %b", co, ex); end
      ex = str2vec("10000000");
      checks++;
      if (cfs !== ex) begin errors++; $display("FAIL single_fs got %b exp %b", cfs, ex); end
      ex = str2vec("11111000");
      checks++;
      if (cb !== ex) begin errors++; $display("FAIL single_busy got %b exp %b", cb, ex); end
      ex = str2vec("00000100");
      checks++;
      if (cd !== ex) begin errors++; $display("FAIL single_done got %b exp %b", cd, ex); end
      checks++;
      if (cfc[5] !== 4'd0 || cfc[6] !== 4'd1 || cfc[8] !== 4'd1) begin
         errors++;
         $display("FAIL single_fcnt got %0d/%0d/%0d exp 0/1/1", cfc[5], cfc[6], cfc[8]);
      end
   endtask

   task automatic test_gap();
      do_start(4'd3, 4'd2, 1'b0);
      capture(22, 0, 0, 0);
      ex = str2vec("1111100111110011111000");
      checks++;
      if (cv !== ex) begin errors++; $display("FAIL gap_valid got %b exp %b", cv, ex); end
      ex = str2vec("1001000100100010010000");
      checks++;
      if (co !== ex) begin errors++; $display("FAIL gap_out got %b exp %b", co, ex); end
      ex = str2vec("1000000100000010000000");
      checks++;
      if (cfs !== ex) begin errors++; $display("FAIL gap_fs got %b exp %b", cfs, ex); end
      ex = str2vec("1111111111111111111000");
      checks++;
      if (cb !== ex) begin errors++; $display("FAIL gap_busy got %b exp %b", cb, ex); end
      ex = str2vec("0000000000000000000100");
      checks++;
      if (cd !== ex) begin errors++; $display("FAIL gap_done got %b exp %b", cd, ex); end
      checks++;
      if (cfc[12] !== 4'd1 || cfc[13] !== 4'd2 || cfc[20] !== 4'd3) begin
         errors++;
         $display("FAIL gap_fcnt got %0d/%0d/%0d exp 1/2/3", cfc[12], cfc[13], cfc[20]);
      end
   endtask

   task automatic test_overlap();
      logic [4:0] hist;
      int hits;
      do_start(4'd3, 4'd7, 1'b1);
      capture(13, 0, 0, 0);
      ex = str2vec("1111111111100");
      checks++;
      if (cv !== ex) begin errors++; $display("FAIL ovl_valid got %b exp %b", cv, ex); end
      ex = str2vec("1001001001000");
      checks++;
      if (co !== ex) begin errors++; $display("FAIL ovl_out got %b exp %b", co, ex); end
      ex = str2vec("1000010010000");
      checks++;
      if (cfs !== ex) begin errors++; $display("FAIL ovl_fs got %b exp %b", cfs, ex); end
      ex = str2vec("0000000000010");
      checks++;
      if (cd !== ex) begin errors++; $display("FAIL ovl_done got %b exp %b", cd, ex); end
      checks++;
      if (cfc[12] !== 4'd3) begin
         errors++;
         $display("FAIL ovl_fcnt got %0d exp 3", cfc[12]);
      end
      // Overlapping 10010 detector over the valid bits
      hist = '0;
      hits = 0;
      for (int k = 1; k <= 13; k++) begin
         if (cv[k]) begin
            hist = {hist[3:0], co[k]};
            if (hist == 5'b10010) hits++;
         end
      end
      checks++;
      if (hits != 3) begin errors++; $display("FAIL ovl_detect got %0d exp 3", hits); end
   endtask

   task automatic test_back_to_back();
      do_start(4'd0, 4'd0, 1'b0);
      capture(7, 0, 0, 0);
      ex = str2vec("1111100");
      checks++;
      if (cv !== ex) begin errors++; $display("FAIL zero_valid got %b exp %b", cv, ex); end
      ex = str2vec("1001000");
      checks++;
      if (co !== ex) begin errors++; $display("FAIL zero_out got %b exp %b", co, ex); end
      ex = str2vec("0000010");
      checks++;
      if (cd !== ex || cfc[6] !== 4'd1) begin
         errors++;
         $display("FAIL zero_done got %b fcnt %0d exp %b fcnt 1", cd, cfc[6], ex);
      end
      do_start(4'd2, 4'd0, 1'b0);
      capture(12, 0, 0, 0);
      ex = str2vec("111111111100");
      checks++;
      if (cv !== ex) begin errors++; $display("FAIL b2b_valid got %b exp %b", cv, ex); end
      ex = str2vec("100101001000");
      checks++;
      if (co !== ex) begin errors++; $display("FAIL b2b_out got %b exp %b", co, ex); end
      ex = str2vec("100001000000");
      checks++;
      if (cfs !== ex) begin errors++; $display("FAIL b2b_fs got %b exp %b", cfs, ex); end
      ex = str2vec("000000000010");
      checks++;
      if (cd !== ex || cfc[11] !== 4'd2) begin
         errors++;
         $display("FAIL b2b_done got %b fcnt %0d exp %b fcnt 2", cd, cfc[11], ex);
      end
   endtask

   task automatic test_start_ignored();
      do_start(4'd2, 4'd1, 1'b0);
      capture(14, 3, 12, 0);
      ex = str2vec("11111011111000");
      checks++;
      if (cv !== ex) begin errors++; $display("FAIL ign_valid got %b exp %b", cv, ex); end
      ex = str2vec("00000000000100");
      checks++;
      if (cd !== ex) begin errors++; $display("FAIL ign_done got %b exp %b", cd, ex); end
      ex = str2vec("11111111111000");
      checks++;
      if (cb !== ex) begin errors++; $display("FAIL ign_busy got %b exp %b", cb, ex); end
   endtask

   task automatic test_abort();
      do_start(4'd3, 4'd2, 1'b0);
      capture(15, 0, 0, 10);
      ex = str2vec("111110011100000");
      checks++;
      if (cv !== ex) begin errors++; $display("FAIL abort_valid got %b exp %b", cv, ex); end
      ex = str2vec("111111111100000");
      checks++;
      if (cb !== ex) begin errors++; $display("FAIL abort_busy got %b exp %b", cb, ex); end
      checks++;
      if (cd !== 64'd0) begin errors++; $display("FAIL abort_done got %b exp 0", cd); end
      checks++;
      if (cfc[11] !== 4'd1 || cfc[15] !== 4'd1) begin
         errors++;
         $display("FAIL abort_fcnt got %0d/%0d exp 1/1", cfc[11], cfc[15]);
      end
      // abort held in idle, and together with start: start wins
      abort = 1'b1;
      repeat (2) @(negedge clk);
      do_start(4'd1, 4'd0, 1'b0);
      capture(7, 0, 0, 0);
      ex = str2vec("1111100");
      checks++;
      if (cv !== ex) begin errors++; $display("FAIL abort_start_valid got %b exp %b", cv, ex); end
      ex = str2vec("0000010");
      checks++;
      if (cd !== ex) begin errors++; $display("FAIL abort_start_done got %b exp %b", cd, ex); end
   endtask

   task automatic test_async_reset();
      do_start(4'd3, 4'd0, 1'b1);
      @(negedge clk);
      checks++;
      if ({out, out_valid, frame_start, busy} !== 4'b1111) begin
         errors++;
         $display("FAIL arst_pre got %b exp 1111", {out, out_valid, frame_start, busy});
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({out, out_valid, frame_start, busy, done} !== 5'b0 || frame_cnt !== 4'd0) begin
         errors++;
         $display("FAIL arst_now got %b fcnt %0d exp 00000 fcnt 0",
                  {out, out_valid, frame_start, busy, done}, frame_cnt);
      end
      @(negedge clk);
      rst = 1'b1;
      do_start(4'd1, 4'd0, 1'b0);
      capture(7, 0, 0, 0);
      ex = str2vec("1001000");
      checks++;
      if (co !== ex) begin errors++; $display("FAIL arst_out got %b exp %b", co, ex); end
      ex = str2vec("1000000");
      checks++;
      if (cfs !== ex) begin errors++; $display("FAIL arst_fs got %b exp %b", cfs, ex); end
      ex = str2vec("0000010");
      checks++;
      if (cd !== ex || cfc[6] !== 4'd1) begin
         errors++;
         $display("FAIL arst_done got %b fcnt %0d exp %b fcnt 1", cd, cfc[6], ex);
      end
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      repeat_cnt = 4'd0;
      gap        = 4'd0;
      overlap    = 1'b0;
      abort      = 1'b0;
      test_reset();
      test_single();
      test_gap();
      test_overlap();
      test_back_to_back();
      test_start_ignored();
      test_abort();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sequence_generator_10010.md
Name: sequence_generator_10010

Overview:
Serial pattern transmitter that drives a bit stream for the 10010 sequence detector. On a start request it emits a configurable number of PATTERN frames, MSB first, one bit per clock. Frames are separated by a programmable idle gap, or overlapped on the shared prefix/suffix when requested. It serves as the stimulus/transmit side of the detector link and can be reused as a generic serial pattern source.

Parameters:
PAT_LEN, 5, pattern length in bits (2..16)
PATTERN, 5'b10010, transmitted pattern, bit PAT_LEN-1 sent first
OVL_LEN, 2, bits shared between consecutive frames in overlap mode; must be < PAT_LEN
COUNT_W, 4, width of repeat_cnt
GAP_W, 4, width of gap

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-low reset (rst=0 resets)
start  input  1  request a burst; sampled only while busy=0
repeat_cnt  input  COUNT_W  frames per burst; 0 treated as 1
gap  input  GAP_W  idle cycles between frames (non-overlap mode)
overlap  input  1  1 = back-to-back overlapped frames, gap ignored
abort  input  1  synchronous burst cancel
out  output  1  serial data bit
out_valid  output  1  out carries a pattern bit this cycle
frame_start  output  1  first emitted bit of each frame
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion
frame_cnt  output  COUNT_W  frames fully emitted in current/last burst

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; out=0, out_valid=0, frame_start=0, busy=0, done=0, frame_cnt=0. Outputs are registered.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: start=1 latches repeat_cnt (0->1), gap and overlap into internal registers. Also clears frame_cnt, loads bit index = PAT_LEN-1, and moves to SHIFT. busy=1 from the next cycle.
- Latency: first bit (PATTERN[PAT_LEN-1]) appears with out_valid=1 and frame_start=1 in the cycle after start is sampled.
- SHIFT: one pattern bit per cycle, index decrementing. After bit 0, frame_cnt increments, visible in the cycle after bit 0. Next state:
  - remaining frames=0 -> DONE.
  - overlap=1 -> SHIFT, index reloaded to PAT_LEN-1-OVL_LEN; that bit carries frame_start=1. No bubble.
  - overlap=0 and gap=0 -> SHIFT, full frame reloaded at PAT_LEN-1. No bubble.
  - otherwise -> GAP.
- GAP: out_valid=0, out=0 for exactly gap cycles, then SHIFT with a full frame.
- DONE: single cycle; done=1, busy=0, out_valid=0; then IDLE. frame_cnt holds its final value until the next start.
- out=0 whenever out_valid=0.
- start while busy=1: ignored, not queued. start in the DONE cycle: ignored.
- abort=1 while busy: next cycle enters IDLE, busy=0, out_valid=0, no done pulse, frame_cnt frozen. abort in IDLE has no effect. If abort and start arrive together in IDLE, start wins.
- Mid-burst changes on repeat_cnt/gap/overlap have no effect (values latched at start).
- Bits per burst:
  - overlap=1: PAT_LEN + (N-1)*(PAT_LEN-OVL_LEN).
  - overlap=0: N*PAT_LEN bits plus (N-1)*gap idle cycles.
- Reset asserted mid-burst: immediate return to reset values. No done.

Test Plan:
- Reset, then start with repeat_cnt=1, gap=3, overlap=0 -> out_valid high cycles 1..5 with out=1,0,0,1,0; frame_start only on cycle 1; done in cycle 6; frame_cnt=1.
- repeat_cnt=3, gap=2, overlap=0 -> frames at cycles 1-5, 8-12, 15-19; out_valid=0 in cycles 6-7 and 13-14; done in cycle 20; frame_cnt=3.
- repeat_cnt=3, overlap=1 -> contiguous stream 10010 010 010 (11 bits); frame_start on bits 1, 6 and 9; done in cycle 12; a detector in overlap mode fires 3 times.
- repeat_cnt=0, gap=0 -> one frame, identical to repeat_cnt=1. Then repeat_cnt=2, gap=0, overlap=0 -> 10 contiguous bits 1001010010.
- start pulsed during a burst -> no effect; single done. abort at bit 3 of frame 2 -> out_valid=0 next cycle, busy=0, no done, frame_cnt=1.
- rst driven low mid-frame, asynchronous to clk -> outputs zero immediately. After release, a new start produces a clean first frame.
